// File: rtl/mult_datapath_if.sv
// ---------------------------------------------------------------------------
// mult_datapath_if
//   Bundles the signals between the button control unit and the shift-add
//   multiplier datapath. The control unit side drives the strobes and the
//   switch operands. The datapath side returns its status flags and the
//   signed product.
//
//   Signals
//     load      CU -> DP  capture operands, clear accumulator
//     enable    CU -> DP  perform one shift-add step
//     mcand_in  CU -> DP  multiplicand (WIDTH bits)
//     mplier_in CU -> DP  multiplier (WIDTH bits)
//     z_flag    DP -> CU  multiplier register is zero
//     b0        DP -> CU  multiplier register bit 0
//     sign      DP -> CU  product sign bit
//     product   DP -> CU  product, sign applied (2*WIDTH bits)
//     step_cnt  DP -> CU  steps taken since the last load
//
//   Modports
//     master  control unit / testbench side
//     slave   datapath side
// ---------------------------------------------------------------------------
interface mult_datapath_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic                 load;
  logic                 enable;
  logic [WIDTH-1:0]     mcand_in;
  logic [WIDTH-1:0]     mplier_in;
  logic                 z_flag;
  logic                 b0;
  logic                 sign;
  logic [2*WIDTH-1:0]   product;
  logic [CW-1:0]        step_cnt;

  modport master (
    output load,
    output enable,
    output mcand_in,
    output mplier_in,
    input  z_flag,
    input  b0,
    input  sign,
    input  product,
    input  step_cnt
  );

  modport slave (
    input  load,
    input  enable,
    input  mcand_in,
    input  mplier_in,
    output z_flag,
    output b0,
    output sign,
    output product,
    output step_cnt
  );
endinterface

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
//   Sequential shift-add multiplier datapath driven by the button control
//   unit. A load captures the operand magnitudes and clears the accumulator.
//   Each enabled clock then performs one partial-product step. Steps continue
//   until the multiplier register is exhausted. The product is presented
//   combinationally with the sign re-applied.
//
//   Parameters
//     WIDTH     operand width; the product is 2*WIDTH bits
//
//   Ports
//     clk       system clock, rising edge
//     reset     synchronous active-high reset; overrides load and enable
//     bus       mult_datapath_if.slave:
//                 load, enable, mcand_in, mplier_in  (in)
//                 z_flag, b0, sign, product, step_cnt (out)
//
//   Build option
//     MULT_SIGNED_EN  when defined, operands are two's complement and the
//                     datapath multiplies magnitudes and tracks the sign.
//                     When undefined, operands are unsigned and sign stays 0.
// ---------------------------------------------------------------------------
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  mult_datapath_if.slave bus
);

  localparam int              PW      = 2 * WIDTH;
  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic             r_sign;
  logic [CW-1:0]    r_stepCnt;

  logic [WIDTH-1:0] w_mcandMag;
  logic [WIDTH-1:0] w_mplierMag;
  logic             w_signIn;
  logic             w_zFlag;
  logic             w_doStep;
  logic [PW-1:0]    w_accNext;

  // Operand conditioning at load time. In the signed build the most
  // negative value -2^(W-1) negates to itself, and that bit pattern read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
`ifdef MULT_SIGNED_EN
  always_comb begin
    w_mcandMag  = bus.mcand_in;
    w_mplierMag = bus.mplier_in;
    if (bus.mcand_in[WIDTH-1]) begin
      w_mcandMag = -bus.mcand_in;
    end
    if (bus.mplier_in[WIDTH-1]) begin
      w_mplierMag = -bus.mplier_in;
    end
    w_signIn = bus.mcand_in[WIDTH-1] ^ bus.mplier_in[WIDTH-1];
  end
`else
  always_comb begin
    w_mcandMag  = bus.mcand_in;
    w_mplierMag = bus.mplier_in;
    w_signIn    = 1'b0;
  end
`endif

  // A step only happens while multiplier bits remain. Once the multiplier
  // register is zero, the result and step count freeze even if enable stays
  // asserted.
  always_comb begin
    w_zFlag   = (r_mplier == '0);
    w_doStep  = bus.enable && !w_zFlag;
    w_accNext = r_acc;
    if (r_mplier[0]) begin
      w_accNext = r_acc + r_mcand;
    end
  end

  // Datapath registers. Reset has priority, then load (which restarts any
  // multiply in progress), then a single shift-add step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_sign    <= 1'b0;
      r_stepCnt <= '0;
    end else if (bus.load) begin
      r_mcand   <= {{WIDTH{1'b0}}, w_mcandMag};
      r_mplier  <= w_mplierMag;
      r_acc     <= '0;
      r_sign    <= w_signIn;
      r_stepCnt <= '0;
    end else if (w_doStep) begin
      r_acc     <= w_accNext;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_stepCnt <= r_stepCnt + CNT_ONE;
    end
  end

  // Status and result outputs come straight from the registers. The
  // accumulator never exceeds 2^(2W)-1, so negating it in PW bits is exact.
  assign bus.z_flag   = w_zFlag;
  assign bus.b0       = r_mplier[0];
  assign bus.sign     = r_sign;
  assign bus.product  = r_sign ? -r_acc : r_acc;
  assign bus.step_cnt = r_stepCnt;

endmodule

// File: tb/tb_mult_datapath.sv
// ---------------------------------------------------------------------------
// tb_mult_datapath
//   Self-checking bench for mult_datapath. Directed scenarios use hand-derived
//   constants. The randomized scenario compares every cycle against an
//   arithmetic model. The model treats the operation as
//   |a| * (|b| mod 2^steps) with the sign re-applied.
// ---------------------------------------------------------------------------
module tb_mult_datapath;

  localparam int WIDTH = 8;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mult_datapath_if #(.WIDTH(WIDTH)) bus ();

  mult_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state: operand magnitudes, sign, and steps taken.
  int unsigned mMagA;
  int unsigned mMagB;
  int unsigned mSteps;
  bit          mSign;

  task automatic modelLoad(input logic [7:0] a, input logic [7:0] b);
    if (SIGNED_BUILD) begin
      mMagA = a[7] ? (256 - int'(a)) : int'(a);
      mMagB = b[7] ? (256 - int'(b)) : int'(b);
      mSign = a[7] ^ b[7];
    end else begin
      mMagA = int'(a);
      mMagB = int'(b);
      mSign = 1'b0;
    end
    mSteps = 0;
  endtask

  task automatic modelEnable();
    if ((mMagB >> mSteps) != 0) mSteps++;
  endtask

  function automatic logic [15:0] expProduct();
    int unsigned p;
    p = mMagA * (mMagB % (32'd1 << mSteps));
    if (mSign) return 16'(-p);
    return 16'(p);
  endfunction

  function automatic logic expZ();
    return ((mMagB >> mSteps) == 0);
  endfunction

  function automatic logic expB0();
    return ((mMagB >> mSteps) & 1) != 0;
  endfunction

  // One clock with the given strobes. Outputs are sampled 1 time unit after
  // the rising edge.
  task automatic applyStimulus(input bit ld, input bit en,
                               input logic [7:0] a, input logic [7:0] b);
    bus.load      = ld;
    bus.enable    = en;
    bus.mcand_in  = a;
    bus.mplier_in = b;
    @(posedge clk);
    #1;
    if (ld) modelLoad(a, b);
    else if (en) modelEnable();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic applyReset(input bit ld, input bit en);
    reset         = 1'b1;
    bus.load      = ld;
    bus.enable    = en;
    bus.mcand_in  = 8'($urandom);
    bus.mplier_in = 8'($urandom);
    @(posedge clk);
    #1;
    mMagA  = 0;
    mMagB  = 0;
    mSign  = 1'b0;
    mSteps = 0;
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    applyReset(1'b0, 1'b0);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL reset_z got %b exp 1", bus.z_flag); end
    nChecks++; if (bus.b0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_b0 got %b exp 0", bus.b0); end
    nChecks++; if (bus.sign !== 1'b0) begin nFail++; $display("[TB] FAIL reset_sign got %b exp 0", bus.sign); end
    nChecks++; if (bus.product !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_product got %h exp 0000", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd0) begin nFail++; $display("[TB] FAIL reset_cnt got %0d exp 0", bus.step_cnt); end
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 1'b0, 8'd5, 8'd3);
    nChecks++; if (bus.b0 !== 1'b1) begin nFail++; $display("[TB] FAIL basic_load_b0 got %b exp 1", bus.b0); end
    nChecks++; if (bus.z_flag !== 1'b0) begin nFail++; $display("[TB] FAIL basic_load_z got %b exp 0", bus.z_flag); end
    nChecks++; if (bus.product !== 16'd0) begin nFail++; $display("[TB] FAIL basic_load_product got %h exp 0000", bus.product); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.b0 !== 1'b1) begin nFail++; $display("[TB] FAIL basic_s1_b0 got %b exp 1", bus.b0); end
    nChecks++; if (bus.z_flag !== 1'b0) begin nFail++; $display("[TB] FAIL basic_s1_z got %b exp 0", bus.z_flag); end
    nChecks++; if (bus.product !== 16'd5) begin nFail++; $display("[TB] FAIL basic_s1_product got %h exp 0005", bus.product); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL basic_s2_z got %b exp 1", bus.z_flag); end
    repeat (3) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.product !== 16'd15) begin nFail++; $display("[TB] FAIL basic_product got %h exp 000f", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd2) begin nFail++; $display("[TB] FAIL basic_cnt got %0d exp 2", bus.step_cnt); end
  endtask

  task automatic test_sign_and_extremes();
    logic [15:0] exp3;
    logic [15:0] exp4;
    logic [7:0]  op4;
    exp3 = SIGNED_BUILD ? 16'hFFD6 : 16'h05D6;
    applyStimulus(1'b1, 1'b0, 8'hF9, 8'd6);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b0) begin nFail++; $display("[TB] FAIL neg7x6_early_z got %b exp 0", bus.z_flag); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL neg7x6_z got %b exp 1", bus.z_flag); end
    nChecks++; if (bus.step_cnt !== 4'd3) begin nFail++; $display("[TB] FAIL neg7x6_cnt got %0d exp 3", bus.step_cnt); end
    nChecks++; if (bus.product !== exp3) begin nFail++; $display("[TB] FAIL neg7x6_product got %h exp %h", bus.product, exp3); end
    nChecks++; if (bus.sign !== SIGNED_BUILD) begin nFail++; $display("[TB] FAIL neg7x6_sign got %b exp %b", bus.sign, SIGNED_BUILD); end

    op4  = SIGNED_BUILD ? 8'h80 : 8'hFF;
    exp4 = SIGNED_BUILD ? 16'h4000 : 16'hFE01;
    applyStimulus(1'b1, 1'b0, op4, op4);
    repeat (7) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b0) begin nFail++; $display("[TB] FAIL extreme_early_z got %b exp 0", bus.z_flag); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL extreme_z got %b exp 1", bus.z_flag); end
    repeat (2) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.step_cnt !== 4'd8) begin nFail++; $display("[TB] FAIL extreme_cnt got %0d exp 8", bus.step_cnt); end
    nChecks++; if (bus.product !== exp4) begin nFail++; $display("[TB] FAIL extreme_product got %h exp %h", bus.product, exp4); end
    nChecks++; if (bus.sign !== 1'b0) begin nFail++; $display("[TB] FAIL extreme_sign got %b exp 0", bus.sign); end

    applyStimulus(1'b1, 1'b0, 8'h00, 8'hFF);
    repeat (9) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.product !== 16'h0000) begin nFail++; $display("[TB] FAIL zero_signed_product got %h exp 0000", bus.product); end
    nChecks++; if (bus.sign !== SIGNED_BUILD) begin nFail++; $display("[TB] FAIL zero_signed_sign got %b exp %b", bus.sign, SIGNED_BUILD); end
  endtask

  task automatic test_zero_mplier();
    applyStimulus(1'b1, 1'b0, 8'd9, 8'd0);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL zero_mplier_z got %b exp 1", bus.z_flag); end
    repeat (10) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.product !== 16'd0) begin nFail++; $display("[TB] FAIL zero_mplier_product got %h exp 0000", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd0) begin nFail++; $display("[TB] FAIL zero_mplier_cnt got %0d exp 0", bus.step_cnt); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 8'd3, 8'd15);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.product !== 16'd9) begin nFail++; $display("[TB] FAIL b2b_partial got %h exp 0009", bus.product); end
    applyStimulus(1'b1, 1'b1, 8'd2, 8'd2);
    nChecks++; if (bus.product !== 16'd0) begin nFail++; $display("[TB] FAIL b2b_reload_product got %h exp 0000", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd0) begin nFail++; $display("[TB] FAIL b2b_reload_cnt got %0d exp 0", bus.step_cnt); end
    nChecks++; if (bus.b0 !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_reload_b0 got %b exp 0", bus.b0); end
    nChecks++; if (bus.z_flag !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_reload_z got %b exp 0", bus.z_flag); end
    repeat (3) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.product !== 16'd4) begin nFail++; $display("[TB] FAIL b2b_product got %h exp 0004", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd2) begin nFail++; $display("[TB] FAIL b2b_cnt got %0d exp 2", bus.step_cnt); end
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_z got %b exp 1", bus.z_flag); end
  endtask

  task automatic test_reset_midop();
    applyStimulus(1'b1, 1'b0, 8'd7, 8'd9);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    applyReset(1'b1, 1'b1);
    nChecks++; if (bus.z_flag !== 1'b1) begin nFail++; $display("[TB] FAIL midreset_z got %b exp 1", bus.z_flag); end
    nChecks++; if (bus.product !== 16'd0) begin nFail++; $display("[TB] FAIL midreset_product got %h exp 0000", bus.product); end
    nChecks++; if (bus.step_cnt !== 4'd0) begin nFail++; $display("[TB] FAIL midreset_cnt got %0d exp 0", bus.step_cnt); end
    nChecks++; if (bus.sign !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_sign got %b exp 0", bus.sign); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    nChecks++; if (bus.step_cnt !== 4'd0) begin nFail++; $display("[TB] FAIL midreset_hold_cnt got %0d exp 0", bus.step_cnt); end
  endtask

  function automatic logic [7:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int r;
    applyStimulus(1'b1, 1'b0, pickOperand(), pickOperand());
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      applyStimulus(1'b1, 1'($urandom), pickOperand(), pickOperand());
      else if (r == 1) applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      else             applyStimulus(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      nChecks++; if (bus.product !== expProduct()) begin nFail++; $display("[TB] FAIL rand_product cycle %0d got %h exp %h", i, bus.product, expProduct()); end
      nChecks++; if (bus.z_flag !== expZ()) begin nFail++; $display("[TB] FAIL rand_z cycle %0d got %b exp %b", i, bus.z_flag, expZ()); end
      nChecks++; if (bus.b0 !== expB0()) begin nFail++; $display("[TB] FAIL rand_b0 cycle %0d got %b exp %b", i, bus.b0, expB0()); end
      nChecks++; if (bus.sign !== mSign) begin nFail++; $display("[TB] FAIL rand_sign cycle %0d got %b exp %b", i, bus.sign, mSign); end
      nChecks++; if (bus.step_cnt !== 4'(mSteps)) begin nFail++; $display("[TB] FAIL rand_cnt cycle %0d got %0d exp %0d", i, bus.step_cnt, mSteps); end
    end
  endtask

  // Safety net so the run always ends even if the clock stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.load      = 1'b0;
    bus.enable    = 1'b0;
    bus.mcand_in  = '0;
    bus.mplier_in = '0;
    mMagA  = 0;
    mMagB  = 0;
    mSign  = 1'b0;
    mSteps = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sign_and_extremes();
    test_zero_mplier();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
